imem_loader: RTL and testbench

- Writer side of the instruction-memory interface.
- The fetch stage reads 32-bit instruction words from instruction memory by address. This block writes them, replacing back-door memory initialisation in benches and enabling program load from a byte stream.
- Sits between an external byte source (UART/bench driver) and the instruction memory write port. Holds the CPU in reset until the image is written.

---
 rtl/imem_loader_pkg.sv | 13 +
 rtl/imem_loader_byte_assembler.sv | 48 ++++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
package imem_loader_pkg;

  localparam int unsigned IMEM_ADDR_W = 16;
  localparam int unsigned IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a byte stream into DATA_W-bit words, first byte ending up in the MSBs.
module imem_loader_byte_assembler #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        in_data,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    word_valid = 1'b0;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shift_d    = (shift_q << 8) | DATA_W'(in_data);
      word_valid = (cnt_q == LAST);
      cnt_d      = word_valid ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // word is the shift register including the byte accepted this cycle
  assign word = shift_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory and holds the CPU until done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W        = IMEM_ADDR_W,
  parameter int unsigned DATA_W        = IMEM_DATA_W,
  parameter bit          HOLD_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [DATA_W-1:0] imem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic              cpu_hold
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              asm_clear;
  logic              word_valid;
  logic [DATA_W-1:0] word;

  imem_loader_byte_assembler #(
    .DATA_W(DATA_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .accept    (in_valid && in_ready_q),
    .in_data   (in_data),
    .word_valid(word_valid),
    .word      (word)
  );

  // Outputs are registered from the next state, so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    checksum_d = checksum_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_hold_d = cpu_hold_q;
    asm_clear  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          checksum_d = '0;
          asm_clear  = 1'b1;
          if (word_count != '0) begin
            state_d    = RECV;
            addr_d     = base_addr;
            remain_d   = word_count;
            cpu_hold_d = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RECV: begin
        if (word_valid) begin
          state_d    = WRITE;
          wr_addr_d  = addr_q;
          wr_data_d  = word;
          checksum_d = checksum_q ^ word;
        end
      end
      WRITE: begin
        addr_d   = addr_q + ADDR_W'(1);
        remain_d = remain_q - ADDR_W'(1);
        state_d  = (remain_q == ADDR_W'(1)) ? DONE : RECV;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) cpu_hold_d = 1'b0;
    in_ready_d = (state_d == RECV);
    wr_en_d    = (state_d == WRITE);
    busy_d     = (state_d == RECV) || (state_d == WRITE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      checksum_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= HOLD_AT_RESET;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      checksum_q <= checksum_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_hold_q <= cpu_hold_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign checksum     = checksum_q;
  assign cpu_hold     = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_wr_en;
  logic [15:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic        cpu_hold;

  imem_loader #(
    .ADDR_W       (16),
    .DATA_W       (32),
    .HOLD_AT_RESET(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_wr_en  (imem_wr_en),
    .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum),
    .cpu_hold    (cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  logic        wh_q[$];
  int          done_n;
  int          done_cyc;

  always @(negedge clk) begin
    if (imem_wr_en) begin
      wa_q.push_back(imem_wr_addr);
      wd_q.push_back(imem_wr_data);
      wc_q.push_back(cyc);
      wh_q.push_back(cpu_hold);
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0]      base;
    logic [15:0]      count;
    logic [2:0][31:0] w;
    int               gap_len;
    logic [31:0]      csum;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] base, input logic [15:0] count,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input int gap_len,
                              input logic [31:0] csum);
    vec_t v;
    v.base    = base;
    v.count   = count;
    v.w[0]    = w0;
    v.w[1]    = w1;
    v.w[2]    = w2;
    v.gap_len = gap_len;
    v.csum    = csum;
    return v;
  endfunction

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    wh_q.delete();
    done_n   = 0;
    done_cyc = -1;
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that sampled start.
  task automatic do_start(input logic [15:0] base, input logic [15:0] count, output int start_cyc);
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  // Presents a byte until it is accepted; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && !acc; t++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    ok = acc;
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int          start_cyc;
    bit          ok;
    logic [31:0] wrd;
    logic [15:0] ea;
    int          nw;
    clear_log();
    do_start(v.base, v.count, start_cyc);
    ok = 1'b1;
    for (int wi = 0; wi < int'(v.count) && ok; wi++) begin
      wrd = v.w[wi];
      for (int b = 0; b < 4 && ok; b++) begin
        send_byte(wrd[31-8*b -: 8], ok);
        if (wi == 0 && b == 1 && v.gap_len > 0) begin
          in_valid = 1'b0;
          repeat (v.gap_len) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && done_n == 0; t++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    nw = wa_q.size();
    chk({tag, "_write_count"}, 32'(nw), 32'(v.count));
    for (int i = 0; i < nw && i < int'(v.count); i++) begin
      ea = v.base + 16'(i);
      chk({tag, "_addr"}, 32'(wa_q[i]), 32'(ea));
      chk({tag, "_data"}, wd_q[i], v.w[i]);
      chk({tag, "_hold_in_write"}, 32'(wh_q[i]), 32'd1);
      if (i == 0)
        chk({tag, "_first_write_cycle"}, 32'(wc_q[0]), 32'(start_cyc + 4 + v.gap_len));
      else
        chk({tag, "_write_spacing"}, 32'(wc_q[i] - wc_q[i-1]), 32'd5);
    end
    chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(start_cyc + 5 * int'(v.count) + v.gap_len));
    chk({tag, "_checksum"}, checksum, v.csum);
    chk({tag, "_cpu_hold_after"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int  sc;
    bit  ok;
    logic [31:0] w0;
    logic [31:0] w1;

    vecs[0] = mk(16'h0000, 16'd2, 32'h80080001, 32'h01000200, 32'h0, 0, 32'h81080201);
    vecs[1] = mk(16'h0000, 16'd2, 32'h80080001, 32'h01000200, 32'h0, 3, 32'h81080201);
    vecs[2] = mk(16'hFFFF, 16'd2, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 32'hCC99E897);
    vecs[3] = mk(16'h0040, 16'd0, 32'h0, 32'h0, 32'h0, 0, 32'h00000000);
    vecs[4] = mk(16'h0010, 16'd3, 32'h11111111, 32'h22222222, 32'h44444444, 0, 32'h77777777);
    vecs[5] = mk(16'h1234, 16'd1, 32'hA5A5A5A5, 32'h0, 32'h0, 0, 32'hA5A5A5A5);

    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_en", 32'(imem_wr_en), 32'd0);
    chk("rst_wr_addr", 32'(imem_wr_addr), 32'd0);
    chk("rst_wr_data", imem_wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);

    in_valid = 1'b1;
    in_data  = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    end
    in_valid = 1'b0;
    chk("idle_no_writes", 32'(wa_q.size()), 32'd0);

    // Mid-load reset after 6 bytes of a 3-word load.
    clear_log();
    w0 = 32'hCAFEF00D;
    w1 = 32'h0BADC0DE;
    do_start(16'h0020, 16'd3, sc);
    ok = 1'b1;
    for (int b = 0; b < 4 && ok; b++) send_byte(w0[31-8*b -: 8], ok);
    for (int b = 0; b < 2 && ok; b++) send_byte(w1[31-8*b -: 8], ok);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_checksum", checksum, 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("abort_done_pulses", 32'(done_n), 32'd0);
    chk("abort_write_count", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() > 0) begin
      chk("abort_addr", 32'(wa_q[0]), 32'h20);
      chk("abort_data", wd_q[0], 32'hCAFEF00D);
    end

    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i));
      chk("idle_cpu_hold_low", 32'(cpu_hold), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
